output_stream_tx: RTL
=====================

// Module: output_stream_tx
// PURPOSE
//  Receiving end of the execute unit's program-output interface (reg_out/out_valid/halt).
//  Buffers each 3-bit program output in a small FIFO and transmits it to the pin-level
//  host interface with a valid/ready handshake.
//  Marks the final value with tx_last after the program halts, and flags dropped values.
//  Sits between the execute unit and the top-level uo_out/ui_in pin mapping.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  DATA_W  3   width of one program output value
// PORTS
//  clk          in   1                   system clock, all logic on rising edge
//  rst          in   1                   synchronous reset, active-high
//  in_data      in   DATA_W              program output value (execute reg_out)
//  in_valid     in   1                   one-cycle pulse: in_data is a new output
//  in_halt      in   1                   execute halted; level, stays high until reset
//  tx_data      out  DATA_W              value at the FIFO head
//  tx_valid     out  1                   tx_data valid
//  tx_ready     in   1                   host accepts tx_data this cycle
//  tx_last      out  1                   qualifies tx_data as the final program output
//  done         out  1                   halt seen and every buffered value sent
//  overflow     out  1                   sticky: at least one in_valid was dropped
//  level        out  $clog2(DEPTH)+1     current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - Pointers, level and halt_seen clear to 0.
//   - Outputs tx_valid, tx_last, done, overflow and level read 0; tx_data reads 0 while empty.
//   - A reset in the middle of a transfer discards all buffered data; nothing is replayed.
//  Push: in_valid=1 and halt_seen=0 and (level<DEPTH or pop this cycle) -> write in_data at wr_ptr.
//  Pop: tx_valid & tx_ready -> advance rd_ptr.
//  Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  Level update:
//   - push & pop: unchanged
//   - push only: +1
//   - pop only: -1
//  Full case: push and pop in the same cycle with level==DEPTH is legal; the push is
//   accepted and level stays DEPTH.
//  Drop case: in_valid while level==DEPTH and no pop -> value dropped, overflow<=1 (sticky
//   until reset), pointers unchanged.
//  Empty case: tx_valid=0 when level==0; tx_ready is ignored (no underflow).
//  Latency: first-word fall-through. A push at edge N gives tx_valid=1 and tx_data=value
//   in the cycle after edge N. Write data never bypasses combinationally to tx_data.
//  Output stability: while tx_valid=1 and tx_ready=0, tx_data and tx_last hold.
//  Halt tracking:
//   - halt_seen<=1 on the first clk edge with in_halt=1.
//   - in_valid and in_halt in the same cycle: the value is still pushed.
//   - in_valid after halt_seen=1 is ignored and does not set overflow.
//  tx_last = tx_valid & halt_seen & (level==1).
//   - Valid only for the head entry; may rise while tx_valid is already high if halt
//     arrives during a stall.
//  done = halt_seen & (level==0), registered-state derived, no extra cycle.
//   - A program with zero outputs: done=1 the cycle after halt_seen sets; tx_last never asserts.
//  Arithmetic: level is $clog2(DEPTH)+1 bits so DEPTH is representable; no saturation needed.
//  FSM: none beyond the halt_seen flag. The states are RUN (halt_seen=0),
//   DRAIN (halt_seen=1, level>0) and DONE; these are derived, not encoded.
// STRUCTURE
//  Shared package/header:
//   - PROG_OUT_W=3
//   - default FIFO depth
//   - tx pin-mapping bit positions, shared with the top level
//  One sub-module: sync_fifo_fwft
//   - Parameterised DEPTH/DATA_W; clk/rst; push/pop/full/empty/level; FWFT read.
//   - Holds memory and pointers.
//  output_stream_tx wraps sync_fifo_fwft and adds halt_seen, drop/overflow, tx_last and done.
// TESTING
//  1. Reset then in_valid pulses with 5,3,7 and tx_ready=1.
//     -> tx_data 5,3,7 on consecutive beats, each one cycle after its push; level returns to 0.
//  2. tx_ready=0 and 16 pushes (values 0..7 repeating), then a 17th push.
//     -> level=16, overflow=1, the 17th value is absent. With tx_ready=1, exactly 16 values
//        drain in order.
//  3. Full FIFO, tx_ready=1, in_valid=1 in the same cycle.
//     -> push accepted, level stays 16, overflow stays 0.
//  4. Push 4,1, assert in_halt, hold tx_ready=0 for 3 cycles, then release.
//     -> tx_last=0 on value 4 and 1 on value 1; after the last pop done=1.
//        An in_valid after halt changes nothing.
//  5. in_halt with the FIFO empty and no outputs ever produced.
//     -> done=1 one cycle after halt; tx_valid and tx_last stay 0.
//  6. rst=1 mid-drain with level=5.
//     -> the next cycle: level=0, tx_valid=0, overflow=0, done=0; the next push behaves as
//        in test 1.

Source files
------------

// File: rtl/output_stream_tx_pkg.sv
// Purpose : shared constants for the program-output transmit path.
// Latency : n/a (package only).
// Backpres: n/a (package only).
//
// Holds the program output width, the default buffer depth and the bit
// positions used when the tx signals are mapped onto the uo_out/ui_in pins.
package output_stream_tx_pkg;

    // Width of one program output value (execute reg_out).
    localparam int PROG_OUT_W = 3;

    // Default number of buffered program outputs.
    localparam int FIFO_DEPTH_DEFAULT = 16;

    // uo_out pin mapping for the transmit side.
    localparam int UO_TX_DATA_LSB  = 0;
    localparam int UO_TX_VALID_BIT = 3;
    localparam int UO_TX_LAST_BIT  = 4;
    localparam int UO_DONE_BIT     = 5;
    localparam int UO_OVERFLOW_BIT = 6;

    // ui_in pin mapping for the host handshake.
    localparam int UI_TX_READY_BIT = 0;

endpackage : output_stream_tx_pkg

// File: rtl/output_stream_tx_fifo.sv
// Purpose : generic synchronous first-word-fall-through FIFO.
// Latency : a push at edge N is visible on pop_data in the cycle after edge N.
// Backpres: the caller must not push when full without a same-cycle pop, nor pop when empty.
//
// Ports: clk/rst (sync, active-high), push/push_data write side,
//        pop/pop_data read side (pop_data reads 0 while empty),
//        full/empty/level status.
module sync_fifo_fwft #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // The head is read straight from storage; the write port never bypasses
    // to the output, so new data appears one cycle after its push.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: nothing is observable while level is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : sync_fifo_fwft

// File: rtl/output_stream_tx.sv
// Purpose : buffers execute-unit program outputs and sends them to the host pins.
// Latency : first-word fall-through; a value pushed at edge N is offered the cycle after.
// Backpres: tx_ready low holds tx_data/tx_last; in_valid into a full, non-popping FIFO is dropped and flagged.
//
// Ports: clk, rst (sync, active-high)
//        in_data/in_valid/in_halt  - execute unit reg_out, out_valid, halt (level)
//        tx_data/tx_valid/tx_ready - host handshake, tx_last marks the final value
//        done     - halt seen and nothing left to send
//        overflow - sticky, at least one value was dropped
//        level    - current buffer occupancy
module output_stream_tx
    import output_stream_tx_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int DATA_W = PROG_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       in_halt,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_last,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic halt_seen;
    logic fifo_full;
    logic fifo_empty;
    logic accept_req;
    logic push;
    logic pop;
    logic drop;

    // Once the program has halted, further out_valid pulses are not program
    // output, so they are neither buffered nor counted as drops.
    assign accept_req = in_valid & ~halt_seen;
    assign pop        = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = accept_req & (~fifo_full | pop);
    assign drop       = accept_req & fifo_full & ~pop;

    sync_fifo_fwft #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign tx_valid = ~fifo_empty;

    // The head is the final output only when halt has been seen and it is the
    // sole remaining entry; this can rise mid-stall when halt arrives late.
    assign tx_last  = tx_valid & halt_seen & (level == LW'(1));
    assign done     = halt_seen & fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_seen <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_halt) begin
                halt_seen <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule : output_stream_tx
